condition_unit: RTL
===================

CONDITION_UNIT -- requirements
Module: condition_unit

Interface
REQ-001 Port clk, input, 1, single clock; all state updates on the rising edge.
REQ-002 Port reset, input, 1, synchronous, active-high; sampled on the rising edge of clk.
REQ-003 Port alu_flags, input, 4, ALU flag output of the EX instruction, bit order: [3]=N, [2]=Z, [1]=C, [0]=V.
REQ-004 Port ex_valid, input, 1, EX stage holds a real instruction.
REQ-005 Port s_bit_ex, input, 1, EX instruction requests a flag update.
REQ-006 Port id_valid, input, 1, ID stage holds a real instruction.
REQ-007 Port cond_id, input, 4, ARM condition field of the ID instruction.
REQ-008 Port is_branch_id, input, 1, ID instruction is B or BL.
REQ-009 Port stall, input, 1, pipeline hold; registers keep their values while it is high.
REQ-010 Port flags_out, output, 4, status register {N,Z,C,V}; bit [1] drives the ALU carry_input.
REQ-011 Port cond_pass_ex, output, 1, registered condition result for the instruction now in EX.
REQ-012 Port branch_taken, output, 1, registered one-cycle pulse when the branch entering EX is taken.
REQ-013 Port flush_id, output, 1, equal to branch_taken; tells IF/ID to squash the instruction behind the branch.

Function
REQ-014 Flag write enable SHALL be wr_en = ex_valid & s_bit_ex & cond_pass_ex.
REQ-015 Status update: if !stall and wr_en, then on the clock edge flags_out <= alu_flags; otherwise flags_out holds.
REQ-016 Evaluation flags: eff = wr_en ? alu_flags : flags_out. This bypass gives zero-bubble compare-then-branch.
REQ-017 Condition decode on eff:
- 0000 EQ Z
- 0001 NE !Z
- 0010 CS C
- 0011 CC !C
- 0100 MI N
- 0101 PL !N
- 0110 VS V
- 0111 VC !V
- 1000 HI C&!Z
- 1001 LS !C|Z
- 1010 GE N==V
- 1011 LT N!=V
- 1100 GT !Z&(N==V)
- 1101 LE Z|(N!=V)
- 1110 AL 1
- 1111 NV 0
REQ-018 pass_id = id_valid & !branch_taken & decode(cond_id, eff). An instruction fetched behind a taken branch never passes.
REQ-019 If !stall, then on the clock edge cond_pass_ex <= pass_id and branch_taken <= pass_id & is_branch_id.
REQ-020 If stall, then cond_pass_ex, branch_taken and flags_out SHALL all hold. A branch_taken pulse held across a stall remains asserted until the first non-stalled edge, then clears.
REQ-021 Evaluation latency: condition result is visible exactly one cycle after ID presentation.
REQ-022 Flag update latency: flags_out is updated one cycle after the EX flag write.
REQ-023 A flag-setting instruction whose condition failed (cond_pass_ex=0) SHALL NOT update flags and SHALL NOT be bypassed.
REQ-024 Consecutive flag writers: the later one wins. Each ID evaluation sees the flags of the instruction immediately ahead of it.
REQ-025 All logic except the registers of REQ-015 and REQ-019 SHALL be combinational; there are no other states.

Reset
REQ-026 On reset, flags_out=4'b0000, cond_pass_ex=0, branch_taken=0 and flush_id=0.
REQ-027 Reset has priority over stall and over any flag write in the same cycle.
REQ-028 Reset mid-stall or mid-branch SHALL clear the pending pulse; the first post-reset evaluation uses flags 0000.

Verification
REQ-029 Reset, then cond_id=0000 EQ, id_valid=1 -> cond_pass_ex=0 next cycle, since Z=0.
REQ-030 CMP bypass:
- stimulus: ex_valid=1, s_bit_ex=1, cond_pass_ex=1, alu_flags=0110 (Z,C); ID holds BEQ (cond 0000, is_branch_id=1)
- response: next cycle branch_taken=1, flush_id=1, flags_out=0110
- following cycle: branch_taken=0, and the ID instruction (cond 1110) yields cond_pass_ex=0 because it is squashed.
REQ-031 Failed-condition flag writer:
- stimulus: flags_out=0000, cond_pass_ex=0, s_bit_ex=1, alu_flags=1000
- response: flags_out stays 0000; a following MI instruction gets cond_pass_ex=0.
REQ-032 Signed compares with N=1, V=0 (flags 1000):
- GE -> 0
- LT -> 1
- GT -> 0
- LE -> 1
- cond 1111 -> 0 under every flag value.
REQ-033 Stall for 3 cycles with branch_taken=1 and a flag write pending -> all outputs frozen for 3 cycles; on release branch_taken clears once and flags_out updates once.
REQ-034 Reset asserted in the same cycle as a flag write of 1111 and a taken branch -> next cycle flags_out=0000, branch_taken=0.

Source files
------------

// File: rtl/condition_unit.sv
// Condition evaluation and status-flag register for a short ARM-style pipeline.
// Evaluates the ID instruction's condition against EX-bypassed flags and issues branch flushes.
module condition_unit (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] alu_flags,
   input  logic       ex_valid,
   input  logic       s_bit_ex,
   input  logic       id_valid,
   input  logic [3:0] cond_id,
   input  logic       is_branch_id,
   input  logic       stall,
   output logic [3:0] flags_out,
   output logic       cond_pass_ex,
   output logic       branch_taken,
   output logic       flush_id
);

   logic [3:0] flags_q;
   logic       pass_q;
   logic       taken_q;

   logic       wr_en;
   logic [3:0] eff;
   logic       n_f, z_f, c_f, v_f;
   logic       base_true;
   logic       cond_true;
   logic       pass_id;

   // A failed flag setter is neither committed nor forwarded.
   assign wr_en = ex_valid & s_bit_ex & pass_q;
   assign eff   = wr_en ? alu_flags : flags_q;

   assign n_f = eff[3];
   assign z_f = eff[2];
   assign c_f = eff[1];
   assign v_f = eff[0];

   // Odd condition codes are the complement of the even code below them.
   always_comb begin
      base_true = 1'b0;
      unique case (cond_id[3:1])
         3'b000: base_true = z_f;
         3'b001: base_true = c_f;
         3'b010: base_true = n_f;
         3'b011: base_true = v_f;
         3'b100: base_true = c_f & ~z_f;
         3'b101: base_true = (n_f == v_f);
         3'b110: base_true = ~z_f & (n_f == v_f);
         3'b111: base_true = 1'b1;
         default: base_true = 1'b0;
      endcase
      cond_true = base_true ^ cond_id[0];
   end

   assign pass_id = id_valid & ~taken_q & cond_true;

   always_ff @(posedge clk) begin
      if (reset) begin
         flags_q <= 4'b0000;
         pass_q  <= 1'b0;
         taken_q <= 1'b0;
      end else if (!stall) begin
         if (wr_en) flags_q <= alu_flags;
         pass_q  <= pass_id;
         taken_q <= pass_id & is_branch_id;
      end
   end

   assign flags_out    = flags_q;
   assign cond_pass_ex = pass_q;
   assign branch_taken = taken_q;
   assign flush_id     = taken_q;

endmodule
